imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Parametrised, pipelined immediate generator for the multi-cycle and pipelined core variants. It accepts an instruction word and an immediate-format selector through a valid/ready handshake and returns the XLEN-wide extended immediate one cycle later. A 2-entry skid buffer allows full throughput under downstream backpressure. It adds RV64 support, a shift-amount format, illegal-format flagging and a saturating error counter.

Parameters:
XLEN, 32, datapath width; legal values are 32 and 64 only.
CNT_W, 8, width of the illegal-format event counter.
TAG_W, 5, width of the sideband tag (e.g. rd or ROB index) carried alongside each immediate.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept an input beat.
in_instr  in  32  instruction word.
in_imm_src  in  3  format selector.
in_tag  in  TAG_W  sideband tag, passed through unchanged.
out_valid  out  1  output beat valid.
out_ready  in  1  consumer accepts the output beat.
out_imm  out  XLEN  extended immediate.
out_tag  out  TAG_W  tag belonging to out_imm.
out_illegal  out  1  the beat used imm_src 3'b111.
err_count  out  CNT_W  saturating count of accepted illegal beats.
err_clr  in  1  synchronous clear of err_count.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, skid entry invalid, in_ready=1, out_imm=0, out_tag=0, out_illegal=0, err_count=0. Reset asserted mid-transfer discards all in-flight beats.
- Formats (SX = sign-extend from instr[31] to XLEN):
  - 000 I: SX(instr[31:20]).
  - 001 S: SX({instr[31:25],instr[11:7]}).
  - 010 B: SX({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 011 U (LUI): SX({instr[31:12],12'b0}).
  - 101 U (AUIPC): same as 011.
  - 100 J: SX({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 110 SHAMT: zero-extended instr[24:20] when XLEN=32; instr[25:20] when XLEN=64.
  - 111 ILLEGAL: imm=0, out_illegal=1.
- Extension logic is combinational on the input side. The result is registered. Latency is exactly 1 cycle from the accepting edge to out_valid when the output stage is free.
- Handshake:
  - A beat transfers on an edge where valid and ready are both high.
  - in_ready = !skid_valid. It is a registered signal and never combinational on out_ready.
  - While out_valid=1 and out_ready=0, out_imm, out_tag and out_illegal hold stable.
- Skid buffer, per edge:
  - Accepted beat, output stage empty or being drained with no skid entry: the beat loads the output register.
  - Accepted beat, output stalled (out_valid && !out_ready): the beat loads the skid entry.
  - Output drained while the skid entry is valid: the skid entry moves to the output register and the skid is cleared.
  - Simultaneous accept and drain with the skid empty: the new beat loads the output register and out_valid stays 1.
  - in_ready=0 whenever the skid is occupied, so no beat is ever accepted into a full buffer.
- Ordering: strictly FIFO, with no loss or duplication.
- err_count:
  - Increments on each accepted beat with imm_src=111.
  - Saturates at 2^CNT_W-1.
  - err_clr has priority over a same-cycle increment; the result is 0.

Decomposition:
- Shared package (rv_pkg): imm_src encoding constants (IMM_I=3'b000 … IMM_ILL=3'b111) and an XLEN default constant. The control decoder uses the same package.
- Sub-module imm_ext_comb: the pure combinational format mux, parametrised on XLEN. The top holds the output register, skid entry, handshake and counter.

Test Plan:
- XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), src 000, out_ready=1 -> 0xFFFFFFFF one cycle later.
- instr 0x0020A423 (sw x2,8(x1)), src 001 -> 0x00000008. instr 0xFE000EE3 (beq -4), src 010 -> 0xFFFFFFFC.
- XLEN=64, instr 0x80000037, src 011 -> 0xFFFFFFFF80000000. instr 0x02109093 (slli shamt 33), src 110 -> 33.
- Stream tags 1..6 back-to-back, hold out_ready=0 for 3 cycles after the first output -> in_ready drops after exactly 2 held beats; after release, tags emerge 1..6 in order with none lost or duplicated.
- CNT_W=2, send 5 accepted beats with src 111 -> out_illegal=1 and imm=0 each; err_count reads 1,2,3,3,3; err_clr in the same cycle as a 6th illegal beat -> 0.
- Assert rst_n low while out_valid=1 and the skid is full -> out_valid=0 and in_ready=1 immediately; no stale beat appears after reset release.

Source files
------------

// File: rtl/rv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv_pkg
//  Brief    : Shared RISC-V definitions: immediate-format selector encodings
//             and the default datapath width.
//  Revision : 1.0  initial release
// ============================================================================
package rv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef logic [2:0] imm_src_t;

    localparam imm_src_t IMM_I     = 3'b000;
    localparam imm_src_t IMM_S     = 3'b001;
    localparam imm_src_t IMM_B     = 3'b010;
    localparam imm_src_t IMM_U     = 3'b011;
    localparam imm_src_t IMM_J     = 3'b100;
    localparam imm_src_t IMM_UA    = 3'b101;
    localparam imm_src_t IMM_SHAMT = 3'b110;
    localparam imm_src_t IMM_ILL   = 3'b111;

endpackage
`default_nettype wire

// File: rtl/imm_ext_comb.sv
`default_nettype none
// ============================================================================
//  Module   : imm_ext_comb
//  Brief    : Pure combinational immediate format mux. Builds a 32-bit
//             sign-extended immediate, then widens it to XLEN (32 or 64).
//  Revision : 1.0  initial release
// ============================================================================
module imm_ext_comb
    import rv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_src,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [31:0] imm32;

    // Format decode to a 32-bit immediate; shamt keeps bit 31 clear so the
    // widening step below zero-extends it.
    always_comb begin
        imm32   = '0;
        illegal = 1'b0;
        case (imm_src)
            IMM_I:         imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:         imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:         imm32 = {{20{instr[31]}}, instr[7], instr[30:25],
                                    instr[11:8], 1'b0};
            IMM_U, IMM_UA: imm32 = {instr[31:12], 12'h000};
            IMM_J:         imm32 = {{12{instr[31]}}, instr[19:12], instr[20],
                                    instr[30:21], 1'b0};
            IMM_SHAMT:     imm32 = {26'b0, instr[25] & (XLEN == 64), instr[24:20]};
            default: begin
                imm32   = '0;
                illegal = 1'b1;
            end
        endcase
    end

    // Widen to the datapath; only 32 and 64 are legal XLEN values.
    if (XLEN == 64) begin : g_xlen64
        assign imm = {{32{imm32[31]}}, imm32};
    end else begin : g_xlen32
        assign imm = imm32;
    end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_gen_pipe
//  Brief    : Pipelined immediate generator. One-cycle registered output with
//             a 2-entry (output + skid) buffer behind a valid/ready handshake,
//             plus a saturating counter of accepted illegal-format beats.
//  Revision : 1.0  initial release
// ============================================================================
module imm_gen_pipe
    import rv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clr
);

    logic [XLEN-1:0]  ext_imm;
    logic             ext_ill;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q,   out_imm_d;
    logic [TAG_W-1:0] out_tag_q,   out_tag_d;
    logic             out_ill_q,   out_ill_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,  skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,  skid_tag_d;
    logic             skid_ill_q,  skid_ill_d;
    logic             in_ready_q,  in_ready_d;
    logic [CNT_W-1:0] err_q,       err_d;

    logic             accept;
    logic             drain;

    imm_ext_comb #(
        .XLEN (XLEN)
    ) u_ext (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (ext_imm),
        .illegal (ext_ill)
    );

    assign accept = in_valid && in_ready_q;
    assign drain  = out_valid_q && out_ready;

    // Next-state for output stage, skid entry, ready flag and error counter.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_tag_d    = out_tag_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;
        skid_ill_d   = skid_ill_q;
        err_d        = err_q;

        if (!out_valid_q || drain) begin
            // Output stage is free this edge; older skid data goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = skid_imm_q;
                out_tag_d    = skid_tag_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                out_valid_d  = 1'b1;
                out_imm_d    = ext_imm;
                out_tag_d    = in_tag;
                out_ill_d    = ext_ill;
            end else begin
                out_valid_d  = 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new beat in the skid entry.
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_imm;
            skid_tag_d   = in_tag;
            skid_ill_d   = ext_ill;
        end

        // Registered ready: drops as soon as the skid entry is occupied.
        in_ready_d = !skid_valid_d;

        if (err_clr) begin
            err_d = '0;
        end else if (accept && ext_ill && (err_q != {CNT_W{1'b1}})) begin
            err_d = err_q + CNT_W'(1);
        end
    end

    // State registers; reset discards every in-flight beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_tag_q    <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
            in_ready_q   <= 1'b1;
            err_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_tag_q    <= out_tag_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
            skid_ill_q   <= skid_ill_d;
            in_ready_q   <= in_ready_d;
            err_q        <= err_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_tag     = out_tag_q;
    assign out_illegal = out_ill_q;
    assign err_count   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_gen_pipe
//  Brief    : Self-checking bench for imm_gen_pipe. Instance A is XLEN=32 with
//             a 2-bit error counter, instance B is XLEN=64 with an 8-bit one.
//  Revision : 1.0  initial release
// ============================================================================
module tb_imm_gen_pipe;

    localparam int TAG_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: XLEN=32, CNT_W=2
    logic             a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0]      a_instr;
    logic [2:0]       a_src;
    logic [TAG_W-1:0] a_tag, a_out_tag;
    logic [31:0]      a_out_imm;
    logic             a_out_ill, a_err_clr;
    logic [1:0]       a_err;

    // Instance B: XLEN=64, CNT_W=8
    logic             b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0]      b_instr;
    logic [2:0]       b_src;
    logic [TAG_W-1:0] b_tag, b_out_tag;
    logic [63:0]      b_out_imm;
    logic             b_out_ill, b_err_clr;
    logic [7:0]       b_err;

    imm_gen_pipe #(.XLEN(32), .CNT_W(2), .TAG_W(TAG_W)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_instr(a_instr), .in_imm_src(a_src), .in_tag(a_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_imm(a_out_imm), .out_tag(a_out_tag), .out_illegal(a_out_ill),
        .err_count(a_err), .err_clr(a_err_clr)
    );

    imm_gen_pipe #(.XLEN(64), .CNT_W(8), .TAG_W(TAG_W)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_instr), .in_imm_src(b_src), .in_tag(b_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_imm(b_out_imm), .out_tag(b_out_tag), .out_illegal(b_out_ill),
        .err_count(b_err), .err_clr(b_err_clr)
    );

    typedef struct {
        logic [63:0]      imm;
        logic [TAG_W-1:0] tag;
        logic             ill;
    } sb_t;

    typedef struct {
        bit               wide;
        logic [31:0]      instr;
        logic [2:0]       src;
        logic [TAG_W-1:0] tag;
        logic [63:0]      imm;
        logic             ill;
    } vec_t;

    sb_t  q_a[$];
    sb_t  q_b[$];
    vec_t vt[12];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   pops_a  = 0;

    // Reference immediate built directly from the format definitions.
    function automatic logic [63:0] model(input logic [31:0] ins, input logic [2:0] src,
                                          input bit wide);
        logic [31:0] t;
        logic [63:0] r;
        case (src)
            3'd0:      t = {{20{ins[31]}}, ins[31:20]};
            3'd1:      t = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            3'd2:      t = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            3'd3, 3'd5: t = {ins[31:12], 12'h000};
            3'd4:      t = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:   t = 32'h0;
        endcase
        if (src == 3'd6) r = wide ? 64'(ins[25:20]) : 64'(ins[24:20]);
        else if (wide)   r = {{32{t[31]}}, t};
        else             r = {32'h0, t};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got output beat, expected none", nm);
    endtask

    // One clock: sample both handshakes just before the edge, then return at
    // the following falling edge where the caller drives new inputs.
    task automatic tick();
        sb_t e;
        #4;
        if (a_out_valid && a_out_ready) begin
            pops_a++;
            if (q_a.size() == 0) sb_fail("sb_a_underflow");
            else begin
                e = q_a.pop_front();
                chk("sb_a_imm", 64'(a_out_imm), e.imm);
                chk("sb_a_tag", 64'(a_out_tag), 64'(e.tag));
                chk("sb_a_ill", 64'(a_out_ill), 64'(e.ill));
            end
        end
        if (b_out_valid && b_out_ready) begin
            if (q_b.size() == 0) sb_fail("sb_b_underflow");
            else begin
                e = q_b.pop_front();
                chk("sb_b_imm", b_out_imm, e.imm);
                chk("sb_b_tag", 64'(b_out_tag), 64'(e.tag));
                chk("sb_b_ill", 64'(b_out_ill), 64'(e.ill));
            end
        end
        if (a_in_valid && a_in_ready) begin
            e.imm = model(a_instr, a_src, 1'b0);
            e.tag = a_tag;
            e.ill = (a_src == 3'b111);
            q_a.push_back(e);
        end
        if (b_in_valid && b_in_ready) begin
            e.imm = model(b_instr, b_src, 1'b1);
            e.tag = b_tag;
            e.ill = (b_src == 3'b111);
            q_b.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  sent_a, sent_b, budget, acc, nxt;
        bit  acc_a, acc_b;
        logic [31:0] hold_imm;
        logic [TAG_W-1:0] hold_tag;

        rst_n = 1'b0;
        a_in_valid = 0; a_instr = 0; a_src = 0; a_tag = 0; a_out_ready = 0; a_err_clr = 0;
        b_in_valid = 0; b_instr = 0; b_src = 0; b_tag = 0; b_out_ready = 0; b_err_clr = 0;

        vt[0]  = '{0, 32'hFFF00093, 3'd0, 5'd1,  64'h00000000FFFFFFFF, 1'b0};
        vt[1]  = '{0, 32'h0020A423, 3'd1, 5'd2,  64'h0000000000000008, 1'b0};
        vt[2]  = '{0, 32'hFE000EE3, 3'd2, 5'd3,  64'h00000000FFFFFFFC, 1'b0};
        vt[3]  = '{0, 32'hFFDFF06F, 3'd4, 5'd4,  64'h00000000FFFFFFFC, 1'b0};
        vt[4]  = '{0, 32'h02109093, 3'd6, 5'd5,  64'h0000000000000001, 1'b0};
        vt[5]  = '{0, 32'h80000037, 3'd3, 5'd6,  64'h0000000080000000, 1'b0};
        vt[6]  = '{1, 32'h80000037, 3'd3, 5'd7,  64'hFFFFFFFF80000000, 1'b0};
        vt[7]  = '{1, 32'h80000017, 3'd5, 5'd8,  64'hFFFFFFFF80000000, 1'b0};
        vt[8]  = '{1, 32'h02109093, 3'd6, 5'd9,  64'h0000000000000021, 1'b0};
        vt[9]  = '{1, 32'hFFF00093, 3'd0, 5'd10, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vt[10] = '{1, 32'hFFFFFFFF, 3'd7, 5'd11, 64'h0000000000000000, 1'b1};
        vt[11] = '{1, 32'h7FF00093, 3'd0, 5'd12, 64'h00000000000007FF, 1'b0};

        // ---- reset state ----
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_out_imm",   64'(a_out_imm),   64'd0);
        chk("rst_out_tag",   64'(a_out_tag),   64'd0);
        chk("rst_out_ill",   64'(a_out_ill),   64'd0);
        chk("rst_err",       64'(a_err),       64'd0);
        chk("rst_b_valid",   64'(b_out_valid), 64'd0);

        // ---- table-driven format vectors, 1-cycle latency ----
        a_out_ready = 1; b_out_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (vt[i].wide) begin
                b_in_valid = 1; b_instr = vt[i].instr; b_src = vt[i].src; b_tag = vt[i].tag;
            end else begin
                a_in_valid = 1; a_instr = vt[i].instr; a_src = vt[i].src; a_tag = vt[i].tag;
            end
            tick();
            a_in_valid = 0; b_in_valid = 0;
            if (vt[i].wide) begin
                chk($sformatf("vec%0d_valid", i), 64'(b_out_valid), 64'd1);
                chk($sformatf("vec%0d_imm", i),   b_out_imm,         vt[i].imm);
                chk($sformatf("vec%0d_tag", i),   64'(b_out_tag),   64'(vt[i].tag));
                chk($sformatf("vec%0d_ill", i),   64'(b_out_ill),   64'(vt[i].ill));
            end else begin
                chk($sformatf("vec%0d_valid", i), 64'(a_out_valid), 64'd1);
                chk($sformatf("vec%0d_imm", i),   64'(a_out_imm),   vt[i].imm);
                chk($sformatf("vec%0d_tag", i),   64'(a_out_tag),   64'(vt[i].tag));
                chk($sformatf("vec%0d_ill", i),   64'(a_out_ill),   64'(vt[i].ill));
            end
            tick();
        end
        chk("b_err_after_table", 64'(b_err), 64'd1);

        // ---- error counter saturation (CNT_W=2) and clear priority ----
        a_err_clr = 1; tick(); a_err_clr = 0;
        chk("err_clr_idle", 64'(a_err), 64'd0);
        for (int k = 0; k < 5; k++) begin
            a_in_valid = 1; a_src = 3'b111; a_instr = $urandom; a_tag = TAG_W'(k);
            tick();
            a_in_valid = 0;
            chk($sformatf("err_cnt_%0d", k), 64'(a_err), (k < 3) ? 64'(k + 1) : 64'd3);
            chk($sformatf("err_ill_%0d", k), 64'(a_out_ill), 64'd1);
            chk($sformatf("err_imm_%0d", k), 64'(a_out_imm), 64'd0);
        end
        a_in_valid = 1; a_src = 3'b111; a_instr = $urandom; a_tag = 5'd9; a_err_clr = 1;
        tick();
        a_in_valid = 0; a_err_clr = 0;
        chk("err_clr_vs_inc", 64'(a_err), 64'd0);
        tick();

        // ---- backpressure: tags 1..6, out_ready low for 3 cycles ----
        a_out_ready = 0; acc = 0; nxt = 1; pops_a = 0;
        a_in_valid = 1; a_instr = $urandom; a_src = 3'($urandom_range(0, 6)); a_tag = 5'd1;
        for (int c = 0; c < 3; c++) begin
            acc_a = a_in_valid && a_in_ready;
            if (c == 2) begin hold_imm = a_out_imm; hold_tag = a_out_tag; end
            tick();
            if (acc_a) begin
                acc++; nxt++;
                a_instr = $urandom; a_src = 3'($urandom_range(0, 6)); a_tag = TAG_W'(nxt);
            end
        end
        chk("bp_held_beats", 64'(acc), 64'd2);
        chk("bp_in_ready",   64'(a_in_ready), 64'd0);
        chk("bp_hold_imm",   64'(a_out_imm),  64'(hold_imm));
        chk("bp_hold_tag",   64'(a_out_tag),  64'(hold_tag));
        chk("bp_head_tag",   64'(a_out_tag),  64'd1);
        a_out_ready = 1; budget = 0;
        while ((nxt <= 6 || q_a.size() != 0) && budget < 50) begin
            acc_a = a_in_valid && a_in_ready;
            tick();
            budget++;
            if (acc_a) begin
                nxt++;
                if (nxt > 6) a_in_valid = 0;
                else begin
                    a_instr = $urandom; a_src = 3'($urandom_range(0, 6)); a_tag = TAG_W'(nxt);
                end
            end
        end
        if (budget >= 50) begin
            n_tests++; n_fail++;
            $display("FAIL bp_timeout: got %0d beats pending, expected 0", q_a.size());
        end
        chk("bp_total_out", 64'(pops_a), 64'd6);

        // ---- random traffic on both instances ----
        sent_a = 0; sent_b = 0; budget = 0;
        while ((sent_a < 60 || sent_b < 60 || q_a.size() != 0 || q_b.size() != 0) && budget < 2000) begin
            a_out_ready = ($urandom_range(0, 9) < 7);
            b_out_ready = ($urandom_range(0, 9) < 7);
            acc_a = a_in_valid && a_in_ready;
            acc_b = b_in_valid && b_in_ready;
            tick();
            budget++;
            if (acc_a) sent_a++;
            if (acc_b) sent_b++;
            if (acc_a || !a_in_valid) begin
                a_in_valid = (sent_a < 60) && ($urandom_range(0, 3) != 0);
                a_instr = $urandom; a_src = 3'($urandom_range(0, 7)); a_tag = TAG_W'($urandom);
            end
            if (acc_b || !b_in_valid) begin
                b_in_valid = (sent_b < 60) && ($urandom_range(0, 3) != 0);
                b_instr = $urandom; b_src = 3'($urandom_range(0, 7)); b_tag = TAG_W'($urandom);
            end
        end
        if (budget >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL rand_timeout: got %0d/%0d pending, expected 0/0", q_a.size(), q_b.size());
        end
        a_in_valid = 0; b_in_valid = 0;

        // ---- asynchronous reset with both buffer entries full ----
        a_out_ready = 0;
        a_in_valid = 1; a_instr = 32'h00100093; a_src = 3'd0; a_tag = 5'd20;
        tick();
        a_tag = 5'd21;
        tick();
        a_in_valid = 0;
        chk("pre_rst_full",  64'(a_in_ready),  64'd0);
        chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(a_out_valid), 64'd0);
        chk("async_rst_ready", 64'(a_in_ready),  64'd1);
        chk("async_rst_imm",   64'(a_out_imm),   64'd0);
        q_a.delete(); q_b.delete();
        @(negedge clk);
        rst_n = 1'b1; a_out_ready = 1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("post_rst_idle_%0d", c), 64'(a_out_valid), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
